apb4_reg_bridge: RTL and testbench

//  Parametrised APB4 completer bridging onto the CSR register-block bus (req/ack, stall-aware).

---
 rtl/apb4_reg_bridge_pkg.sv | 29 ++
 rtl/apb4_reg_bridge_bus_timeout_cnt.sv | 42 ++++
 rtl/apb4_reg_bridge.sv | 165 ++++++++++++++++
 tb/tb_apb4_reg_bridge.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_reg_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb4_reg_bridge_pkg
// Description : Shared types and helpers for the APB4-to-register-bus bridge.
//               Provides the FSM state encoding, per-lane strobe expansion
//               and the address alignment mask.
// Revision    : 1.0 - initial release
// ============================================================================
package apb4_reg_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // One byte lane: a single strobe bit becomes eight bit-enables.
    function automatic logic [7:0] strb_to_biten(input logic strb);
        return {8{strb}};
    endfunction

    // Mask of the byte-offset bits inside one data word.
    function automatic logic [63:0] align_mask(input int unsigned data_width);
        return (64'd1 << $clog2(data_width / 8)) - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb4_reg_bridge_bus_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout_cnt
// Description : Counts cycles spent waiting for a register-bus ack and flags
//               the last permitted cycle. TIMEOUT_CYCLES = 0 never expires.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] count;

    // Wait-cycle counter: cleared outside the wait window, frozen once expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    // Expiry is raised during the final allowed wait cycle so the FSM leaves
    // after exactly TIMEOUT_CYCLES wait cycles.
    if (TIMEOUT_CYCLES > 0) begin : g_timeout_on
        assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_timeout_off
        assign expired = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/apb4_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb4_reg_bridge
// Description : APB4 completer that forwards accesses onto the CSR register
//               bus (req/ack, stall-aware). Adds alignment / PPROT checks,
//               strobe-to-bit-enable expansion and an ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb4_reg_bridge
    import apb4_reg_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter bit ERR_ON_MISALIGN = 1'b1,
    parameter bit PROT_CHECK      = 1'b0,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [STRB_WIDTH-1:0] pstrb,
    input  logic [2:0]            pprot,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic                  o_bus_req,
    output logic                  o_bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [DATA_WIDTH-1:0] o_bus_wr_data,
    output logic [DATA_WIDTH-1:0] o_bus_wr_biten,
    input  logic                  i_bus_req_stall_rd,
    input  logic                  i_bus_req_stall_wr,
    input  logic                  i_bus_rd_ack,
    input  logic                  i_bus_wr_ack,
    input  logic [DATA_WIDTH-1:0] i_bus_rd_data,
    input  logic                  i_bus_err
);

    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(align_mask(DATA_WIDTH));

    state_t                  state_q, state_d;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   strb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic                    aborted_q;
    logic [DATA_WIDTH-1:0]   biten;
    logic                    access;
    logic                    check_fail;
    logic                    stall;
    logic                    ack_match;
    logic                    cnt_clear;
    logic                    cnt_en;
    logic                    expired;
    logic                    unused_prot;

    // Only privilege (bit 0) is ever inspected; the other PPROT bits are ignored.
    assign unused_prot = ^pprot[2:1];

    assign access     = psel && penable;
    assign check_fail = (ERR_ON_MISALIGN && (|(paddr & LOW_MASK))) ||
                        (PROT_CHECK && !pprot[0]);
    assign stall      = wr_q ? i_bus_req_stall_wr : i_bus_req_stall_rd;
    // Acks for the other direction are never taken, even when both fire.
    assign ack_match  = wr_q ? i_bus_wr_ack : i_bus_rd_ack;
    assign cnt_clear  = (state_q != ST_WAIT);
    assign cnt_en     = (state_q == ST_WAIT);

    for (genvar i = 0; i < STRB_WIDTH; i++) begin : g_biten
        assign biten[8*i +: 8] = strb_to_biten(strb_q[i]);
    end

    bus_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expired(expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a failed check skips the bus entirely; an ack wins over a
    // timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (access) state_d = check_fail ? ST_RESP : ST_REQ;
            ST_REQ:  if (!stall) state_d = ST_WAIT;
            ST_WAIT: if (ack_match || expired) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the access, then latch the bus outcome (or the timeout error).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        wr_q      <= pwrite;
                        addr_q    <= paddr & ~LOW_MASK;
                        wdata_q   <= pwdata;
                        strb_q    <= pstrb;
                        rdata_q   <= '0;
                        err_q     <= check_fail;
                        aborted_q <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (!psel) aborted_q <= 1'b1;
                end
                ST_WAIT: begin
                    if (!psel) aborted_q <= 1'b1;
                    if (ack_match) begin
                        err_q <= i_bus_err;
                        if (!wr_q) rdata_q <= i_bus_rd_data;
                    end else if (expired) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A requester that walked away mid-transfer gets no response.
    assign pready          = (state_q == ST_RESP) && !aborted_q && psel;
    assign prdata          = (pready && !wr_q) ? rdata_q : '0;
    assign pslverr         = pready && err_q;

    assign o_bus_req       = (state_q == ST_REQ);
    assign o_bus_req_is_wr = o_bus_req && wr_q;
    assign o_bus_addr      = o_bus_req ? addr_q  : '0;
    assign o_bus_wr_data   = o_bus_req ? wdata_q : '0;
    assign o_bus_wr_biten  = o_bus_req ? biten   : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb4_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb4_reg_bridge
// Description : Self-checking bench for apb4_reg_bridge with directed
//               scenarios and randomized transfers against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb4_reg_bridge;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [SW-1:0] pstrb = '0;
    logic [2:0]    pprot = 3'b001;
    logic          pready, pslverr;
    logic [DW-1:0] prdata;
    logic          o_bus_req, o_bus_req_is_wr;
    logic [AW-1:0] o_bus_addr;
    logic [DW-1:0] o_bus_wr_data, o_bus_wr_biten;
    logic          i_bus_req_stall_rd = 1'b0, i_bus_req_stall_wr = 1'b0;
    logic          i_bus_rd_ack = 1'b0, i_bus_wr_ack = 1'b0, i_bus_err = 1'b0;
    logic [DW-1:0] i_bus_rd_data = '0;

    int checks = 0;
    int passed = 0;

    // Observations gathered by run_xfer.
    int            obs_req_n, obs_lat, obs_ready_n;
    bit            obs_stable, obs_hung;
    logic [AW-1:0] obs_addr;
    logic          obs_wr;
    logic [DW-1:0] obs_wdata, obs_biten, obs_prdata;
    logic          obs_pslverr;

    apb4_reg_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO),
        .ERR_ON_MISALIGN(1'b1), .PROT_CHECK(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .o_bus_req(o_bus_req), .o_bus_req_is_wr(o_bus_req_is_wr), .o_bus_addr(o_bus_addr),
        .o_bus_wr_data(o_bus_wr_data), .o_bus_wr_biten(o_bus_wr_biten),
        .i_bus_req_stall_rd(i_bus_req_stall_rd), .i_bus_req_stall_wr(i_bus_req_stall_wr),
        .i_bus_rd_ack(i_bus_rd_ack), .i_bus_wr_ack(i_bus_wr_ack),
        .i_bus_rd_data(i_bus_rd_data), .i_bus_err(i_bus_err)
    );

    always #5 clk = ~clk;

    // Reference: every set strobe opens a full byte lane.
    function automatic logic [DW-1:0] model_biten(input logic [SW-1:0] strb);
        logic [DW-1:0] b;
        b = '0;
        for (int i = 0; i < SW; i++) if (strb[i]) b = b | (32'hFF << (8 * i));
        return b;
    endfunction

    task automatic clear_bus_inputs();
        i_bus_req_stall_rd = 1'b0; i_bus_req_stall_wr = 1'b0;
        i_bus_rd_ack = 1'b0; i_bus_wr_ack = 1'b0; i_bus_err = 1'b0;
        i_bus_rd_data = $urandom;
    endtask

    // APB master plus register-bus agent. ack_delay < 0 means no ack ever.
    task automatic run_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input int stall_n, input int ack_delay,
                            input logic [DW-1:0] ack_data, input bit ack_err, input bit noise);
        bit accepted = 0;
        bit done = 0;
        int wcnt = 0;
        obs_req_n = 0; obs_lat = -1; obs_ready_n = 0; obs_stable = 1; obs_hung = 0;
        obs_prdata = '0; obs_pslverr = 1'b0;
        obs_addr = '0; obs_wr = 1'b0; obs_wdata = '0; obs_biten = '0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(posedge clk); #1;
            clear_bus_inputs();
            if (pready) begin
                obs_lat = cyc; obs_prdata = prdata; obs_pslverr = pslverr;
                obs_ready_n++; done = 1;
            end else if (o_bus_req) begin
                if (obs_req_n == 0) begin
                    obs_addr = o_bus_addr; obs_wr = o_bus_req_is_wr;
                    obs_wdata = o_bus_wr_data; obs_biten = o_bus_wr_biten;
                end else if ({obs_addr, obs_wr, obs_wdata, obs_biten} !==
                             {o_bus_addr, o_bus_req_is_wr, o_bus_wr_data, o_bus_wr_biten}) begin
                    obs_stable = 0;
                end
                obs_req_n++;
                if (obs_req_n <= stall_n) begin
                    if (wr) i_bus_req_stall_wr = 1'b1; else i_bus_req_stall_rd = 1'b1;
                end else begin
                    accepted = 1;
                end
                if (noise) begin
                    if (wr) i_bus_req_stall_rd = 1'b1; else i_bus_req_stall_wr = 1'b1;
                end
            end else if (accepted) begin
                if (noise) begin
                    if (wr) i_bus_rd_ack = 1'b1; else i_bus_wr_ack = 1'b1;
                    i_bus_err = 1'($urandom);
                end
                if (wcnt == ack_delay) begin
                    if (wr) i_bus_wr_ack = 1'b1; else i_bus_rd_ack = 1'b1;
                    i_bus_rd_data = ack_data; i_bus_err = ack_err;
                end
                wcnt++;
            end
        end
        penable = 1'b0;
        if (done) begin
            @(posedge clk); #1;
            clear_bus_inputs();
            if (pready) obs_ready_n++;
        end else begin
            obs_hung = 1;
        end
        psel = 1'b0;
        clear_bus_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ((pready | pslverr | o_bus_req | o_bus_req_is_wr | (|prdata) | (|o_bus_addr) |
             (|o_bus_wr_data) | (|o_bus_wr_biten)) !== 1'b0)
            $display("FAIL reset_outputs: got nonzero/X outputs, expected all 0");
        else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_strobe();
        run_xfer(1, 8'h04, 32'hDEADBEEF, 4'b0101, 0, 0, '0, 0, 0);
        checks++; if (obs_biten !== 32'h00FF00FF) $display("FAIL wr_biten: got %h expected 00ff00ff", obs_biten); else passed++;
        checks++; if ({obs_wr, obs_addr, obs_wdata} !== {1'b1, 8'h04, 32'hDEADBEEF})
            $display("FAIL wr_fields: got wr=%b addr=%h data=%h expected 1 04 deadbeef", obs_wr, obs_addr, obs_wdata); else passed++;
        checks++; if (obs_lat !== 3) $display("FAIL wr_latency: got %0d expected 3", obs_lat); else passed++;
        checks++; if ({obs_pslverr, obs_ready_n} !== {1'b0, 32'd1})
            $display("FAIL wr_resp: got err=%b pready_cycles=%0d expected 0 1", obs_pslverr, obs_ready_n); else passed++;
    endtask

    task automatic test_read_stall();
        run_xfer(0, 8'h08, '0, 4'h0, 3, 0, 32'h12345678, 0, 0);
        checks++; if ({obs_req_n, obs_stable} !== {32'd4, 1'b1})
            $display("FAIL rd_stall_req: got req_cycles=%0d stable=%b expected 4 1", obs_req_n, obs_stable); else passed++;
        checks++; if ({obs_wr, obs_addr} !== {1'b0, 8'h08}) $display("FAIL rd_stall_addr: got wr=%b addr=%h expected 0 08", obs_wr, obs_addr); else passed++;
        checks++; if (obs_prdata !== 32'h12345678) $display("FAIL rd_stall_data: got %h expected 12345678", obs_prdata); else passed++;
        checks++; if (obs_lat !== 6) $display("FAIL rd_stall_latency: got %0d expected 6", obs_lat); else passed++;
    endtask

    task automatic test_misalign();
        run_xfer(0, 8'h02, '0, 4'h0, 0, 0, 32'hFFFFFFFF, 0, 0);
        checks++; if (obs_req_n !== 0) $display("FAIL misalign_req: got %0d req cycles expected 0", obs_req_n); else passed++;
        checks++; if ({obs_lat, obs_pslverr, obs_prdata} !== {32'd1, 1'b1, 32'd0})
            $display("FAIL misalign_resp: got lat=%0d err=%b data=%h expected 1 1 0", obs_lat, obs_pslverr, obs_prdata); else passed++;
    endtask

    task automatic test_timeout();
        run_xfer(0, 8'h10, '0, 4'h0, 0, -1, '0, 0, 1);
        checks++; if (obs_lat !== TO + 2) $display("FAIL timeout_latency: got %0d expected %0d", obs_lat, TO + 2); else passed++;
        checks++; if ({obs_pslverr, obs_prdata, obs_ready_n} !== {1'b1, 32'd0, 32'd1})
            $display("FAIL timeout_resp: got err=%b data=%h cycles=%0d expected 1 0 1", obs_pslverr, obs_prdata, obs_ready_n); else passed++;
    endtask

    task automatic test_reset_in_flight();
        bit seen = 0;
        // Reset while the request is held by a stall: request must vanish at once.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge clk); #1; penable = 1'b1; i_bus_req_stall_wr = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_bus_req !== 1'b1) $display("FAIL rst_req_pre: got o_bus_req=%b expected 1", o_bus_req); else passed++;
        rst_n = 1'b0; #1;
        checks++;
        if ((pready | pslverr | o_bus_req | o_bus_req_is_wr | (|prdata) | (|o_bus_addr) |
             (|o_bus_wr_data) | (|o_bus_wr_biten)) !== 1'b0)
            $display("FAIL rst_req_outputs: got nonzero/X outputs, expected all 0");
        else passed++;
        psel = 1'b0; penable = 1'b0; clear_bus_inputs();
        @(posedge clk); #1; rst_n = 1'b1;
        // Reset while in WAIT, then a stale ack must not produce a response.
        psel = 1'b1; pwrite = 1'b0; paddr = 8'h24;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        checks++; if ((pready | o_bus_req | (|prdata)) !== 1'b0) $display("FAIL rst_wait_outputs: got nonzero/X outputs, expected 0"); else passed++;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1; i_bus_rd_ack = 1'b1; i_bus_rd_data = 32'h55AA55AA;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; clear_bus_inputs();
            if (pready || o_bus_req) seen = 1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL rst_stale_ack: got activity=%b expected 0", seen); else passed++;
        run_xfer(0, 8'h2C, '0, 4'h0, 0, 1, 32'h0BADCAFE, 0, 0);
        checks++; if ({obs_lat, obs_prdata, obs_pslverr} !== {32'd4, 32'h0BADCAFE, 1'b0})
            $display("FAIL rst_next_access: got lat=%0d data=%h err=%b expected 4 0badcafe 0", obs_lat, obs_prdata, obs_pslverr); else passed++;
    endtask

    task automatic test_psel_drop();
        bit req_seen = 0;
        bit resp_seen = 0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h30; pwdata = 32'h11112222; pstrb = 4'hF;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1;
        req_seen = o_bus_req;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1; i_bus_wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; clear_bus_inputs();
            if (pready) resp_seen = 1;
        end
        checks++; if ({req_seen, resp_seen} !== 2'b10)
            $display("FAIL psel_drop: got req=%b pready=%b expected 1 0", req_seen, resp_seen); else passed++;
        run_xfer(1, 8'h34, 32'h33334444, 4'b1000, 0, 0, '0, 0, 0);
        checks++; if ({obs_lat, obs_biten, obs_pslverr} !== {32'd3, 32'hFF000000, 1'b0})
            $display("FAIL psel_drop_next: got lat=%0d biten=%h err=%b expected 3 ff000000 0", obs_lat, obs_biten, obs_pslverr); else passed++;
    endtask

    task automatic test_back_to_back();
        run_xfer(1, 8'h40, 32'hA0A0A0A0, 4'hF, 0, 0, '0, 0, 0);
        checks++; if ({obs_pslverr, obs_ready_n, obs_biten} !== {1'b0, 32'd1, 32'hFFFFFFFF})
            $display("FAIL b2b_wr0: got err=%b cycles=%0d biten=%h expected 0 1 ffffffff", obs_pslverr, obs_ready_n, obs_biten); else passed++;
        run_xfer(1, 8'h44, 32'hB0B0B0B0, 4'h0, 0, 0, '0, 0, 0);
        checks++; if ({obs_pslverr, obs_ready_n, obs_req_n, obs_biten} !== {1'b0, 32'd1, 32'd1, 32'd0})
            $display("FAIL b2b_wr1: got err=%b cycles=%0d req=%0d biten=%h expected 0 1 1 0", obs_pslverr, obs_ready_n, obs_req_n, obs_biten); else passed++;
        run_xfer(0, 8'h48, '0, 4'h0, 0, 0, 32'hA5A5A5A5, 1, 1);
        checks++; if ({obs_pslverr, obs_ready_n, obs_prdata} !== {1'b1, 32'd1, 32'hA5A5A5A5})
            $display("FAIL b2b_rd_err: got err=%b cycles=%0d data=%h expected 1 1 a5a5a5a5", obs_pslverr, obs_ready_n, obs_prdata); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            bit            wr = 1'($urandom_range(0, 1));
            logic [AW-1:0] addr = AW'($urandom_range(0, 255));
            logic [DW-1:0] data = $urandom;
            logic [SW-1:0] strb = SW'($urandom_range(0, 15));
            int            stall_n = $urandom_range(0, 3);
            int            dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            logic [DW-1:0] ack_data = $urandom;
            bit            ack_err = ($urandom_range(0, 3) == 0);
            bit            noise = 1'($urandom_range(0, 1));
            bit            mis;
            int            exp_lat;
            bit            exp_err;
            logic [DW-1:0] exp_rd;
            if ($urandom_range(0, 3) != 0) addr = (addr / 4) * 4;
            mis     = (addr % 4) != 0;
            exp_lat = mis ? 1 : (dly < 0 ? stall_n + 2 + TO : stall_n + 3 + dly);
            exp_err = mis || (dly < 0) || ack_err;
            exp_rd  = (!wr && !mis && dly >= 0) ? ack_data : '0;
            run_xfer(wr, addr, data, strb, stall_n, dly, ack_data, ack_err, noise);
            checks++; if (obs_hung) $display("FAIL rand%0d timeout: no pready within bound", n); else passed++;
            checks++; if (obs_req_n !== (mis ? 0 : stall_n + 1)) $display("FAIL rand%0d req_cycles: got %0d expected %0d", n, obs_req_n, mis ? 0 : stall_n + 1); else passed++;
            if (!mis) begin
                checks++; if ({obs_stable, obs_wr, obs_addr} !== {1'b1, wr, AW'((addr / 4) * 4)})
                    $display("FAIL rand%0d req_fields: got stable=%b wr=%b addr=%h expected 1 %b %h", n, obs_stable, obs_wr, obs_addr, wr, AW'((addr / 4) * 4)); else passed++;
                if (wr) begin
                    checks++; if ({obs_wdata, obs_biten} !== {data, model_biten(strb)})
                        $display("FAIL rand%0d wr_payload: got %h/%h expected %h/%h", n, obs_wdata, obs_biten, data, model_biten(strb)); else passed++;
                end
            end
            checks++; if (obs_lat !== exp_lat) $display("FAIL rand%0d latency: got %0d expected %0d", n, obs_lat, exp_lat); else passed++;
            checks++; if ({obs_pslverr, obs_prdata, obs_ready_n} !== {exp_err, exp_rd, 32'd1})
                $display("FAIL rand%0d resp: got err=%b data=%h cycles=%0d expected %b %h 1", n, obs_pslverr, obs_prdata, obs_ready_n, exp_err, exp_rd); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_write_strobe();
        test_read_stall();
        test_misalign();
        test_timeout();
        test_reset_in_flight();
        test_psel_drop();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
